// File: rtl/eth_rx_dma_ring_ctrl.sv
// Ring controller for Ethernet RX DMA: issues one iDMA 1D request per ring slot,
// waits for the backend response, advances the producer index and raises an irq.
module eth_rx_dma_ring_ctrl #(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned TFLenWidth = 32,
  parameter int unsigned IdxWidth   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_enable_i,
  input  logic [AddrWidth-1:0]  cfg_base_i,
  input  logic [TFLenWidth-1:0] cfg_slot_len_i,
  input  logic [IdxWidth:0]     cfg_num_slots_i,
  input  logic [IdxWidth-1:0]   sw_rd_idx_i,
  output logic [AddrWidth-1:0]  req_dst_addr_o,
  output logic [AddrWidth-1:0]  req_src_addr_o,
  output logic [TFLenWidth-1:0] req_length_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  input  logic                  rsp_valid_i,
  input  logic                  rsp_error_i,
  output logic                  rsp_ready_o,
  output logic [IdxWidth-1:0]   wr_idx_o,
  output logic                  ring_full_o,
  output logic                  irq_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam logic [IdxWidth:0] MinSlots = (IdxWidth+1)'(2);
  localparam logic [IdxWidth:0] MaxSlots = {1'b1, {IdxWidth{1'b0}}};
  localparam logic [IdxWidth:0] OneSlot  = (IdxWidth+1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StIssue,
    StWait,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [AddrWidth-1:0]  base_q, base_d;
  logic [TFLenWidth-1:0] len_q, len_d;
  logic [IdxWidth:0]     num_q, num_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;

  logic [IdxWidth:0]     num_clamped;
  logic [IdxWidth-1:0]   cur_idx;
  logic [IdxWidth-1:0]   next_idx;
  logic                  last_slot;

  // Clamp the configured slot count into the usable range 2..2**IdxWidth
  always_comb begin
    num_clamped = cfg_num_slots_i;
    if (cfg_num_slots_i < MinSlots) begin
      num_clamped = MinSlots;
    end else if (cfg_num_slots_i > MaxSlots) begin
      num_clamped = MaxSlots;
    end
  end

  // Successor index with explicit wrap at N-1; IDLE evaluates as if the ring were empty
  always_comb begin
    cur_idx   = (state_q == StIdle) ? '0 : idx_q;
    last_slot = ({1'b0, cur_idx} == (num_q - OneSlot));
    next_idx  = last_slot ? '0 : (cur_idx + IdxWidth'(1));
  end

  assign ring_full_o    = (next_idx == sw_rd_idx_i);
  assign req_dst_addr_o = addr_q;
  assign req_src_addr_o = '0;
  assign req_length_o   = len_q;
  assign wr_idx_o       = idx_q;
  assign irq_o          = irq_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != StIdle);

  // Next-state and handshake outputs for the single-outstanding request FSM
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    len_d       = len_q;
    num_d       = num_q;
    idx_d       = idx_q;
    err_d       = err_q;
    irq_d       = 1'b0;
    req_valid_o = 1'b0;
    rsp_ready_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (cfg_enable_i) begin
          base_d  = cfg_base_i;
          addr_d  = cfg_base_i;
          len_d   = cfg_slot_len_i;
          num_d   = num_clamped;
          idx_d   = '0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (!cfg_enable_i) begin
          state_d = StIdle;
        end else if (!ring_full_o) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        req_valid_o = 1'b1;
        if (req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        rsp_ready_o = 1'b1;
        if (rsp_valid_i) begin
          if (rsp_error_i) begin
            err_d   = 1'b1;
            state_d = StError;
          end else begin
            idx_d   = next_idx;
            addr_d  = last_slot ? base_q : (addr_q + AddrWidth'(len_q));
            irq_d   = 1'b1;
            state_d = StArm;
          end
        end
      end
      StError: begin
        if (!cfg_enable_i) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      num_q   <= MinSlots;
      idx_q   <= '0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_eth_rx_dma_ring_ctrl.sv
// Self-checking bench for eth_rx_dma_ring_ctrl: directed ring scenarios followed by
// randomized traffic, all checked against a slot-level model of the ring.
module tb_eth_rx_dma_ring_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        cfg_enable_i;
  logic [63:0] cfg_base_i;
  logic [31:0] cfg_slot_len_i;
  logic [4:0]  cfg_num_slots_i;
  logic [3:0]  sw_rd_idx_i;
  logic [63:0] req_dst_addr_o;
  logic [63:0] req_src_addr_o;
  logic [31:0] req_length_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic        rsp_error_i;
  logic        rsp_ready_o;
  logic [3:0]  wr_idx_o;
  logic        ring_full_o;
  logic        irq_o;
  logic        err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  // Slot-level reference model: destination is always base + index * slot length
  logic [63:0] mBase;
  int unsigned mLen;
  int          mN;
  int          mIdx;
  int          mRd;
  bit          mActive;

  eth_rx_dma_ring_ctrl #(
    .AddrWidth (64),
    .TFLenWidth(32),
    .IdxWidth  (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cfg_enable_i   (cfg_enable_i),
    .cfg_base_i     (cfg_base_i),
    .cfg_slot_len_i (cfg_slot_len_i),
    .cfg_num_slots_i(cfg_num_slots_i),
    .sw_rd_idx_i    (sw_rd_idx_i),
    .req_dst_addr_o (req_dst_addr_o),
    .req_src_addr_o (req_src_addr_o),
    .req_length_o   (req_length_o),
    .req_valid_o    (req_valid_o),
    .req_ready_i    (req_ready_i),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_error_i    (rsp_error_i),
    .rsp_ready_o    (rsp_ready_o),
    .wr_idx_o       (wr_idx_o),
    .ring_full_o    (ring_full_o),
    .irq_o          (irq_o),
    .err_o          (err_o),
    .busy_o         (busy_o)
  );

  // Free-running clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic bit modelFull();
    if (!mActive) return (mRd == 1);
    return (((mIdx + 1) % mN) == mRd);
  endfunction

  function automatic logic [63:0] modelDst();
    return mBase + 64'(mIdx) * 64'(mLen);
  endfunction

  task automatic waitCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input logic [63:0] base, input int unsigned len,
                               input int n, input int rd);
    cfg_enable_i    = en;
    cfg_base_i      = base;
    cfg_slot_len_i  = len;
    cfg_num_slots_i = 5'(n);
    sw_rd_idx_i     = 4'(rd);
    mBase   = base;
    mLen    = len;
    mN      = (n < 2) ? 2 : n;
    mRd     = rd;
    mIdx    = 0;
    mActive = en;
  endtask

  // Acts as the iDMA backend for one request and checks the controller around it
  task automatic serviceRequest(input int readyDelay, input int rspDelay, input bit withErr,
                                input bit dropEnable, input int newRd);
    int budget;
    logic [63:0] expDst;
    budget = 0;
    while (req_valid_o !== 1'b1 && budget < 20) begin
      waitCycle();
      budget++;
    end
    expDst = modelDst();
    checkOutput("req_valid", 64'(req_valid_o), 64'd1);
    checkOutput("req_dst", req_dst_addr_o, expDst);
    checkOutput("req_len", 64'(req_length_o), 64'(mLen));
    checkOutput("req_src", req_src_addr_o, 64'd0);
    for (int i = 0; i < readyDelay; i++) begin
      waitCycle();
      checkOutput("hold_valid", 64'(req_valid_o), 64'd1);
      checkOutput("hold_dst", req_dst_addr_o, expDst);
      checkOutput("hold_len", 64'(req_length_o), 64'(mLen));
    end
    req_ready_i = 1'b1;
    waitCycle();
    req_ready_i = 1'b0;
    checkOutput("post_hs_valid", 64'(req_valid_o), 64'd0);
    checkOutput("wait_rsp_ready", 64'(rsp_ready_o), 64'd1);
    if (dropEnable) cfg_enable_i = 1'b0;
    for (int i = 0; i < rspDelay; i++) begin
      waitCycle();
      checkOutput("wait_hold_ready", 64'(rsp_ready_o), 64'd1);
      checkOutput("wait_no_irq", 64'(irq_o), 64'd0);
      checkOutput("wait_no_valid", 64'(req_valid_o), 64'd0);
    end
    rsp_valid_i = 1'b1;
    rsp_error_i = withErr;
    waitCycle();
    rsp_valid_i = 1'b0;
    rsp_error_i = 1'b0;
    if (withErr) begin
      checkOutput("err_set", 64'(err_o), 64'd1);
      checkOutput("err_no_irq", 64'(irq_o), 64'd0);
      checkOutput("err_wr_idx", 64'(wr_idx_o), 64'(mIdx));
      checkOutput("err_rsp_ready", 64'(rsp_ready_o), 64'd0);
    end else begin
      mIdx = (mIdx + 1) % mN;
      checkOutput("irq_pulse", 64'(irq_o), 64'd1);
      checkOutput("wr_idx", 64'(wr_idx_o), 64'(mIdx));
      checkOutput("no_err", 64'(err_o), 64'd0);
      sw_rd_idx_i = 4'(newRd);
      mRd = newRd;
      if (dropEnable) mActive = 1'b0;
      waitCycle();
      checkOutput("irq_single", 64'(irq_o), 64'd0);
      checkOutput("ring_full", 64'(ring_full_o), 64'(modelFull()));
      checkOutput("next_valid", 64'(req_valid_o), 64'(mActive && !modelFull()));
      checkOutput("busy", 64'(busy_o), 64'(mActive));
    end
  endtask

  // Directed scenarios, then randomized traffic, then async reset during a request
  initial begin
    logic [63:0] randBase;
    int budget;
    rst_ni      = 1'b0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_error_i = 1'b0;
    applyStimulus(1'b0, 64'd0, 0, 0, 0);
    repeat (3) waitCycle();
    checkOutput("rst_valid", 64'(req_valid_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_wr_idx", 64'(wr_idx_o), 64'd0);
    checkOutput("rst_irq", 64'(irq_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
    checkOutput("rst_full", 64'(ring_full_o), 64'd0);
    checkOutput("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    checkOutput("rst_dst", req_dst_addr_o, 64'd0);
    rst_ni = 1'b1;
    waitCycle();

    $display("[TB] basic ring fill");
    applyStimulus(1'b1, 64'h0000_0000_8000_0000, 1536, 4, 0);
    waitCycle();
    checkOutput("arm_busy", 64'(busy_o), 64'd1);
    checkOutput("arm_no_valid", 64'(req_valid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      serviceRequest(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 0);
    end
    checkOutput("fill_wr_idx", 64'(wr_idx_o), 64'd3);
    checkOutput("fill_full", 64'(ring_full_o), 64'd1);
    repeat (5) begin
      waitCycle();
      checkOutput("full_no_valid", 64'(req_valid_o), 64'd0);
    end

    $display("[TB] consumer advance and wrap");
    sw_rd_idx_i = 4'd2;
    mRd = 2;
    serviceRequest(0, 0, 1'b0, 1'b0, 2);
    serviceRequest(1, 2, 1'b0, 1'b0, 2);
    checkOutput("wrap_full", 64'(ring_full_o), 64'd1);

    $display("[TB] backpressure on request");
    sw_rd_idx_i = 4'd0;
    mRd = 0;
    serviceRequest(10, 1, 1'b0, 1'b0, 0);

    $display("[TB] disable while waiting");
    serviceRequest(0, 2, 1'b0, 1'b1, 0);
    checkOutput("drop_busy", 64'(busy_o), 64'd0);
    checkOutput("drop_wr_idx", 64'(wr_idx_o), 64'd3);
    sw_rd_idx_i = 4'd1;
    mRd = 1;
    waitCycle();
    checkOutput("idle_full", 64'(ring_full_o), 64'(modelFull()));

    $display("[TB] error response");
    applyStimulus(1'b1, 64'h0000_0000_8000_0000, 1536, 4, 0);
    serviceRequest(0, 1, 1'b0, 1'b0, 0);
    serviceRequest(1, 0, 1'b1, 1'b0, 0);
    repeat (5) begin
      waitCycle();
      checkOutput("error_no_valid", 64'(req_valid_o), 64'd0);
      checkOutput("error_sticky", 64'(err_o), 64'd1);
      checkOutput("error_busy", 64'(busy_o), 64'd1);
    end
    cfg_enable_i = 1'b0;
    waitCycle();
    checkOutput("error_cleared", 64'(err_o), 64'd0);
    checkOutput("error_idle", 64'(busy_o), 64'd0);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 2; r++) begin
      randBase = 64'hFFFF_FFFF_FFFF_0000 | 64'($urandom_range(0, 65535));
      applyStimulus(1'b1, randBase, $urandom_range(1, 4096),
                    (r == 0) ? 1 : int'($urandom_range(2, 8)), 0);
      for (int t = 0; t < 20; t++) begin
        if (modelFull()) begin
          repeat (3) begin
            waitCycle();
            checkOutput("rand_full_hold", 64'(req_valid_o), 64'd0);
            checkOutput("rand_full_flag", 64'(ring_full_o), 64'd1);
          end
          sw_rd_idx_i = 4'(mIdx);
          mRd = mIdx;
        end
        serviceRequest(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0,
                       (r == 0) && (t == 19), int'($urandom_range(0, mN - 1)));
      end
    end

    $display("[TB] async reset during request");
    sw_rd_idx_i = 4'(mIdx);
    mRd = mIdx;
    if (mIdx == 0) begin
      serviceRequest(0, 0, 1'b0, 1'b0, (mIdx + 1) % mN);
    end
    budget = 0;
    while (req_valid_o !== 1'b1 && budget < 20) begin
      waitCycle();
      budget++;
    end
    checkOutput("pre_rst_valid", 64'(req_valid_o), 64'd1);
    checkOutput("pre_rst_wr_idx_nonzero", 64'(wr_idx_o != 4'd0), 64'd1);
    rst_ni = 1'b0;
    #2;
    checkOutput("async_rst_valid", 64'(req_valid_o), 64'd0);
    checkOutput("async_rst_busy", 64'(busy_o), 64'd0);
    checkOutput("async_rst_wr_idx", 64'(wr_idx_o), 64'd0);
    checkOutput("async_rst_irq", 64'(irq_o), 64'd0);
    cfg_enable_i = 1'b0;
    waitCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
